// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight; handshake -> rsp_valid two edges later, results held until rsp_ready.
// Requests stall while busy; define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [DATA_W-1:0] alu_srca,
    output logic [DATA_W-1:0] alu_srcb,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] opa, opb, res;
    logic [OP_W-1:0]   opc;
    logic              grant, zero_q;
    logic              win, any_req, rsp_done;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    assign any_req = req0_valid | req1_valid;

    // Winner id: 0 = execute stage, 1 = AGU/branch unit.
    always_comb begin
        win = req1_valid & ~req0_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_grant;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = any_req & ~win;
                req1_ready = any_req & win;
                if (any_req) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~grant;
                rsp1_valid = grant;
                rsp_done   = grant ? rsp1_ready : rsp0_ready;
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa    <= '0;
            opb    <= '0;
            opc    <= '0;
            grant  <= 1'b0;
            res    <= '0;
            zero_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            if (state == IDLE && any_req) begin
                opa   <= win ? req1_a  : req0_a;
                opb   <= win ? req1_b  : req0_b;
                opc   <= win ? req1_op : req0_op;
                grant <= win;
            end
            if (state == EXEC) begin
                res    <= alu_result;
                zero_q <= alu_zero;
            end
`ifndef ALU_ARB_FIXED_PRIO_EN
            if (rsp_done) last_grant <= grant;
`endif
        end
    end

    assign alu_srca    = opa;
    assign alu_srcb    = opb;
    assign alu_ctrl    = opc;
    assign rsp0_result = rsp0_valid ? res : '0;
    assign rsp1_result = rsp1_valid ? res : '0;
    assign rsp0_zero   = rsp0_valid & zero_q;
    assign rsp1_zero   = rsp1_valid & zero_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a small behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          grant_log[$];
    logic [33:0] rsp_log[$];
    bit          auto_rdy0 = 1'b1, auto_rdy1 = 1'b1;
    int          rearm0 = 0, rearm1 = 0;
    bit          timed_out;

    alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_result = alu_srca & alu_srcb;
            ALU_OR:  alu_result = alu_srca | alu_srcb;
            ALU_ADD: alu_result = alu_srca + alu_srcb;
            ALU_XOR: alu_result = alu_srca ^ alu_srcb;
            ALU_SUB: alu_result = alu_srca - alu_srcb;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        grant_log.delete();
        rsp_log.delete();
    endtask

    task automatic post_req(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] er, input logic ez);
        if (p == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
            exp_q0.push_back({er, ez});
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
            exp_q1.push_back({er, ez});
        end
    endtask

    // Runs cycles, logging grants and consumed responses, until everything drains.
    task automatic pump(input int max_cycles);
        bit          hs0, hs1;
        logic [32:0] t;
        int          n;
        n = 0;
        timed_out = 1'b1;
        while (n < max_cycles) begin
            @(negedge clk);
            rsp0_ready = auto_rdy0;
            rsp1_ready = auto_rdy1;
            #1;
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (hs0) grant_log.push_back(0);
            if (hs1) grant_log.push_back(1);
            if (rsp0_valid && rsp0_ready) rsp_log.push_back({1'b0, rsp0_result, rsp0_zero});
            if (rsp1_valid && rsp1_ready) rsp_log.push_back({1'b1, rsp1_result, rsp1_zero});
            @(posedge clk);
            #1;
            if (hs0) begin
                if (rearm0 > 0) begin
                    rearm0--;
                    t = exp_q0[exp_q0.size()-1];
                    exp_q0.push_back(t);
                end else req0_valid = 1'b0;
            end
            if (hs1) begin
                if (rearm1 > 0) begin
                    rearm1--;
                    t = exp_q1[exp_q1.size()-1];
                    exp_q1.push_back(t);
                end else req1_valid = 1'b0;
            end
            n++;
            if (!req0_valid && !req1_valid && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: rdy0/rdy1/vld0/vld1/busy=%b want 00000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        n_cmp++;
        if ({alu_srca, alu_srcb, alu_ctrl} !== '0) begin
            n_err++;
            $display("FAIL reset_alu: srca=%h srcb=%h ctrl=%h want 0", alu_srca, alu_srcb, alu_ctrl);
        end
        n_cmp++;
        if ({rsp0_result, rsp0_zero, rsp1_result, rsp1_zero} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp: r0=%h z0=%b r1=%h z1=%b want 0", rsp0_result, rsp0_zero, rsp1_result, rsp1_zero);
        end
    endtask

    task automatic test_single_add();
        logic [32:0] e;
        post_req(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0);
        @(negedge clk); #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL add_ready: rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL add_exec: busy=%b vld0=%b rdy0=%b want 1 0 0", busy, rsp0_valid, req0_ready);
        end
        n_cmp++;
        if (alu_srca !== 32'd5 || alu_srcb !== 32'd7 || alu_ctrl !== ALU_ADD) begin
            n_err++;
            $display("FAIL add_operands: srca=%h srcb=%h ctrl=%h want 5 7 %h", alu_srca, alu_srcb, alu_ctrl, ALU_ADD);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp1_result !== 32'd0) begin
            n_err++;
            $display("FAIL add_latency: vld0=%b vld1=%b r1=%h want 1 0 0", rsp0_valid, rsp1_valid, rsp1_result);
        end
        e = exp_q0.pop_front();
        n_cmp++;
        if ({rsp0_result, rsp0_zero} !== e) begin
            n_err++;
            $display("FAIL add_result: got %h/%b want %h/%b", rsp0_result, rsp0_zero, e[32:1], e[0]);
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        n_cmp++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL add_release: vld0=%b busy=%b want 0 0", rsp0_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic [33:0] r;
        logic [32:0] e;
        int          exp_order[$];
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            grant_log.delete();
            post_req(0, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1);
            post_req(1, 32'hF0, 32'h0F, ALU_XOR, 32'hFF, 1'b0);
            // last_grant is 1 from reset, and 1 again after each pair ends on port 1.
            exp_order = '{0, 1};
            pump(40);
            n_cmp++;
            if (timed_out) begin
                n_err++;
                $display("FAIL pair%0d_timeout: still busy after 40 cycles", pass);
            end
            for (int i = 0; i < exp_order.size(); i++) begin
                n_cmp++;
                if (i >= grant_log.size() || grant_log[i] !== exp_order[i]) begin
                    n_err++;
                    $display("FAIL pair%0d_grant%0d: got %0d want %0d", pass, i,
                             (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
                end
            end
            while (rsp_log.size() > 0) begin
                r = rsp_log.pop_front();
                if (r[33]) e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
                else       e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
                n_cmp++;
                if (r[32:0] !== e) begin
                    n_err++;
                    $display("FAIL pair%0d_rsp%0d: got %h/%b want %h/%b", pass, r[33], r[32:1], r[0], e[32:1], e[0]);
                end
            end
            n_cmp++;
            if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
                n_err++;
                $display("FAIL pair%0d_missing: outstanding p0=%0d p1=%0d want 0 0", pass, exp_q0.size(), exp_q1.size());
            end
        end
    endtask

    task automatic test_rsp_backpressure();
        logic [33:0] r;
        logic [32:0] e;
        bit          seen;
        do_reset();
        rsp1_ready = 1'b0;
        post_req(1, 32'hF0, 32'h0F, ALU_XOR, 32'hFF, 1'b0);
        @(negedge clk); #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: rdy1=%b want 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            seen = rsp1_valid;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL bp_rsp_timeout: rsp1_valid=%b want 1 within 10 cycles", rsp1_valid);
        end
        post_req(0, 32'd1, 32'd2, ALU_ADD, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFF || rsp1_zero !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: vld1=%b r1=%h z1=%b want 1 ff 0", i, rsp1_valid, rsp1_result, rsp1_zero);
            end
            n_cmp++;
            if (req0_ready !== 1'b0 || busy !== 1'b1 || rsp0_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall%0d: rdy0=%b busy=%b vld0=%b want 0 1 0", i, req0_ready, busy, rsp0_valid);
            end
        end
        auto_rdy0 = 1'b1;
        auto_rdy1 = 1'b1;
        pump(40);
        n_cmp++;
        if (timed_out) begin
            n_err++;
            $display("FAIL bp_drain_timeout: still busy after 40 cycles");
        end
        while (rsp_log.size() > 0) begin
            r = rsp_log.pop_front();
            if (r[33]) e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
            else       e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
            n_cmp++;
            if (r[32:0] !== e) begin
                n_err++;
                $display("FAIL bp_rsp%0d: got %h/%b want %h/%b", r[33], r[32:1], r[0], e[32:1], e[0]);
            end
        end
        n_cmp++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_err++;
            $display("FAIL bp_missing: outstanding p0=%0d p1=%0d want 0 0", exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_reset_in_exec();
        bit seen;
        do_reset();
        post_req(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0);
        @(negedge clk); #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rx_accept: rdy0=%b want 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        n_cmp++;
        if (busy !== 1'b1 || alu_srca !== 32'd5) begin
            n_err++;
            $display("FAIL rx_in_exec: busy=%b srca=%h want 1 5", busy, alu_srca);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q0.delete();
        n_cmp++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_srca !== 32'd0) begin
            n_err++;
            $display("FAIL rx_after: busy=%b vld0=%b vld1=%b srca=%h want 0 0 0 0", busy, rsp0_valid, rsp1_valid, alu_srca);
        end
        seen = 1'b0;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
        end
        rsp0_ready = 1'b0;
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL rx_dropped: activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_sustained_contention();
        logic [33:0] r;
        logic [32:0] e;
        int          exp_order[$];
        do_reset();
        auto_rdy0 = 1'b1;
        auto_rdy1 = 1'b1;
        post_req(0, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0);
        post_req(1, 32'h10, 32'h01, ALU_OR, 32'h11, 1'b0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        rearm0 = 3;
        rearm1 = 0;
        exp_order = '{0, 0, 0, 0, 1};
`else
        rearm0 = 2;
        rearm1 = 2;
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        pump(100);
        n_cmp++;
        if (timed_out) begin
            n_err++;
            $display("FAIL sustain_timeout: still busy after 100 cycles");
        end
        n_cmp++;
        if (grant_log.size() != exp_order.size()) begin
            n_err++;
            $display("FAIL sustain_count: got %0d grants want %0d", grant_log.size(), exp_order.size());
        end
        for (int i = 0; i < exp_order.size(); i++) begin
            n_cmp++;
            if (i >= grant_log.size() || grant_log[i] !== exp_order[i]) begin
                n_err++;
                $display("FAIL sustain_grant%0d: got %0d want %0d", i,
                         (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            end
        end
        while (rsp_log.size() > 0) begin
            r = rsp_log.pop_front();
            if (r[33]) e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
            else       e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
            n_cmp++;
            if (r[32:0] !== e) begin
                n_err++;
                $display("FAIL sustain_rsp%0d: got %h/%b want %h/%b", r[33], r[32:1], r[0], e[32:1], e[0]);
            end
        end
        n_cmp++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_err++;
            $display("FAIL sustain_missing: outstanding p0=%0d p1=%0d want 0 0", exp_q0.size(), exp_q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_rsp_backpressure();
        test_reset_in_exec();
        test_sustained_contention();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
